// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_GPR GPRs plus SP, PC, LR and CPSR flags,
// three combinational read ports and two prioritised write ports (W1 over W0).
module register_file_mp #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         NUM_GPR  = 8,
  parameter logic [DATA_W-1:0]   SP_RESET = '0,
  parameter logic [DATA_W-1:0]   PC_RESET = '0,
  parameter bit                  BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rd_a_sel,
  input  logic [3:0]        rd_b_sel,
  input  logic [3:0]        rd_c_sel,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rd_c,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              wr0_en,
  input  logic [3:0]        wr0_dest,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [3:0]        wr1_dest,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              pc_en,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [3:0]        cpsr_we,
  input  logic [3:0]        cpsr_in,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] cpsr_out,
  output logic              wr_conflict
);

  localparam int unsigned SEL_W   = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam logic [SEL_W-1:0] SEL_SP  = SEL_W'(8);
  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(9);
  localparam logic [SEL_W-1:0] SEL_LR  = SEL_W'(10);
  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(15);

  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] sp_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] lr_q;
  logic [FLAG_W-1:0] flags_q;
  logic              conflict_q;

  logic wr0_ok;
  logic wr1_ok;

  // Only GPRs that exist plus SP/PC/LR accept writes.
  function automatic logic is_writable(input logic [SEL_W-1:0] dest);
    return (32'(dest) < NUM_GPR) || (dest == SEL_SP) || (dest == SEL_PC) || (dest == SEL_LR);
  endfunction

  assign wr0_ok = wr0_en && is_writable(wr0_dest);
  assign wr1_ok = wr1_en && is_writable(wr1_dest);

  // Stored value for a selector, overridden by same-cycle write data when bypassing.
  function automatic logic [DATA_W-1:0] read_port(input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int unsigned i = 0; i < NUM_GPR; i++) begin
      if (sel == SEL_W'(i)) val = gpr_q[i];
    end
    case (sel)
      SEL_SP:  val = sp_q;
      SEL_PC:  val = pc_q;
      SEL_LR:  val = lr_q;
      SEL_IMM: val = imm_in;
      default: ;
    endcase
    if (BYPASS && !rst) begin
      if (wr0_ok && (sel == wr0_dest)) val = wr0_data;
      if (wr1_ok && (sel == wr1_dest)) val = wr1_data;
    end
    return val;
  endfunction

  always_comb begin
    rd_a = read_port(rd_a_sel);
    rd_b = read_port(rd_b_sel);
    rd_c = read_port(rd_c_sel);
  end

  assign pc_out      = pc_q;
  assign cpsr_out    = {flags_q, (DATA_W-FLAG_W)'(0)};
  assign wr_conflict = conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      sp_q       <= SP_RESET;
      pc_q       <= PC_RESET;
      lr_q       <= '0;
      flags_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_GPR; i++) begin
        if (wr1_ok && (wr1_dest == SEL_W'(i)))      gpr_q[i] <= wr1_data;
        else if (wr0_ok && (wr0_dest == SEL_W'(i))) gpr_q[i] <= wr0_data;
      end
      if (wr1_ok && (wr1_dest == SEL_SP))      sp_q <= wr1_data;
      else if (wr0_ok && (wr0_dest == SEL_SP)) sp_q <= wr0_data;
      if (wr1_ok && (wr1_dest == SEL_LR))      lr_q <= wr1_data;
      else if (wr0_ok && (wr0_dest == SEL_LR)) lr_q <= wr0_data;
      // Explicit PC writes outrank the fetch-supplied next_pc.
      if (wr1_ok && (wr1_dest == SEL_PC))      pc_q <= wr1_data;
      else if (wr0_ok && (wr0_dest == SEL_PC)) pc_q <= wr0_data;
      else if (pc_en)                          pc_q <= next_pc;
      flags_q <= (flags_q & ~cpsr_we) | (cpsr_in & cpsr_we);
      if (wr0_en && wr1_en && (wr0_dest == wr1_dest)) conflict_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: three builds (no bypass, bypass, 4 GPRs)
// share one stimulus and are checked against hand-computed values.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_a_sel, rd_b_sel, rd_c_sel;
  logic [31:0] imm_in;
  logic        wr0_en, wr1_en;
  logic [3:0]  wr0_dest, wr1_dest;
  logic [31:0] wr0_data, wr1_data;
  logic        pc_en;
  logic [31:0] next_pc;
  logic [3:0]  cpsr_we, cpsr_in;

  logic [31:0] n0_rd_a, n0_rd_b, n0_rd_c, n0_pc, n0_cpsr;
  logic [31:0] b1_rd_a, b1_rd_b, b1_rd_c, b1_pc, b1_cpsr;
  logic [31:0] g4_rd_a, g4_rd_b, g4_rd_c, g4_pc, g4_cpsr;
  logic        n0_conf, b1_conf, g4_conf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(32), .NUM_GPR(8), .SP_RESET(32'h100), .PC_RESET(32'h40), .BYPASS(1'b0)) dut_n0 (
    .clk(clk), .rst(rst), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_c_sel(rd_c_sel),
    .rd_a(n0_rd_a), .rd_b(n0_rd_b), .rd_c(n0_rd_c), .imm_in(imm_in),
    .wr0_en(wr0_en), .wr0_dest(wr0_dest), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_dest(wr1_dest), .wr1_data(wr1_data),
    .pc_en(pc_en), .next_pc(next_pc), .cpsr_we(cpsr_we), .cpsr_in(cpsr_in),
    .pc_out(n0_pc), .cpsr_out(n0_cpsr), .wr_conflict(n0_conf));

  register_file_mp #(.DATA_W(32), .NUM_GPR(8), .SP_RESET(32'h100), .PC_RESET(32'h40), .BYPASS(1'b1)) dut_b1 (
    .clk(clk), .rst(rst), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_c_sel(rd_c_sel),
    .rd_a(b1_rd_a), .rd_b(b1_rd_b), .rd_c(b1_rd_c), .imm_in(imm_in),
    .wr0_en(wr0_en), .wr0_dest(wr0_dest), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_dest(wr1_dest), .wr1_data(wr1_data),
    .pc_en(pc_en), .next_pc(next_pc), .cpsr_we(cpsr_we), .cpsr_in(cpsr_in),
    .pc_out(b1_pc), .cpsr_out(b1_cpsr), .wr_conflict(b1_conf));

  register_file_mp #(.DATA_W(32), .NUM_GPR(4), .SP_RESET(32'h100), .PC_RESET(32'h40), .BYPASS(1'b1)) dut_g4 (
    .clk(clk), .rst(rst), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_c_sel(rd_c_sel),
    .rd_a(g4_rd_a), .rd_b(g4_rd_b), .rd_c(g4_rd_c), .imm_in(imm_in),
    .wr0_en(wr0_en), .wr0_dest(wr0_dest), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_dest(wr1_dest), .wr1_data(wr1_data),
    .pc_en(pc_en), .next_pc(next_pc), .cpsr_we(cpsr_we), .cpsr_in(cpsr_in),
    .pc_out(g4_pc), .cpsr_out(g4_cpsr), .wr_conflict(g4_conf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    wr0_en = 1'b0; wr1_en = 1'b0; pc_en = 1'b0; cpsr_we = 4'b0000;
  endtask

  initial begin
    logic [3:0]  sels [8];
    logic [31:0] exps [8];
    sels = '{4'd0, 4'd3, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
    exps = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h40, 32'h0, 32'h0, 32'h0};

    rst = 1'b0; imm_in = '0; rd_a_sel = '0; rd_b_sel = '0; rd_c_sel = '0;
    wr0_dest = '0; wr1_dest = '0; wr0_data = '0; wr1_data = '0; next_pc = '0;
    cpsr_in = '0;
    idle_writes();

    // Asynchronous reset asserted mid-cycle, before any clock edge
    #3 rst = 1'b1;
    #1;
    foreach (sels[i]) begin
      rd_a_sel = sels[i];
      #1;
      check($sformatf("rst_n0_sel%0d", sels[i]), n0_rd_a, exps[i]);
      check($sformatf("rst_g4_sel%0d", sels[i]), g4_rd_a, exps[i]);
    end
    check("rst_cpsr", b1_cpsr, 32'h0);
    check("rst_conf", {31'b0, b1_conf}, 32'h0);
    check("rst_pc", n0_pc, 32'h40);

    // Writes pending under reset are discarded and not bypassed
    wr0_en = 1'b1; wr0_dest = 4'd3; wr0_data = 32'h55; rd_a_sel = 4'd3;
    #1 check("rst_bypass_b1", b1_rd_a, 32'h0);
    tick();
    check("rst_drop_n0", n0_rd_a, 32'h0);
    idle_writes();
    rst = 1'b0;
    #1;

    // Single write: old value without bypass, new value on all ports with bypass
    wr0_en = 1'b1; wr0_dest = 4'd3; wr0_data = 32'hDEADBEEF;
    rd_a_sel = 4'd3; rd_b_sel = 4'd3; rd_c_sel = 4'd3;
    #1;
    check("w1_n0_same", n0_rd_a, 32'h0);
    check("w1_b1_a", b1_rd_a, 32'hDEADBEEF);
    check("w1_b1_b", b1_rd_b, 32'hDEADBEEF);
    check("w1_b1_c", b1_rd_c, 32'hDEADBEEF);
    tick();
    idle_writes();
    #1;
    check("w1_n0_next", n0_rd_a, 32'hDEADBEEF);
    check("w1_b1_next", b1_rd_c, 32'hDEADBEEF);

    // Different destinations on both ports: no conflict
    wr0_en = 1'b1; wr0_dest = 4'd5; wr0_data = 32'hA5;
    wr1_en = 1'b1; wr1_dest = 4'd6; wr1_data = 32'hB6;
    rd_a_sel = 4'd5; rd_b_sel = 4'd6;
    tick();
    idle_writes();
    #1;
    check("dual_r5", n0_rd_a, 32'hA5);
    check("dual_r6", n0_rd_b, 32'hB6);
    check("dual_noconf", {31'b0, n0_conf}, 32'h0);

    // Same destination: W1 wins, sticky conflict
    wr0_en = 1'b1; wr0_dest = 4'd5; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_dest = 4'd5; wr1_data = 32'h22;
    #1;
    check("conf_bypass_w1", b1_rd_a, 32'h22);
    check("conf_pre", {31'b0, b1_conf}, 32'h0);
    tick();
    idle_writes();
    #1;
    check("conf_r5", n0_rd_a, 32'h22);
    check("conf_set", {31'b0, n0_conf}, 32'h1);
    tick(); tick();
    check("conf_sticky", {31'b0, b1_conf}, 32'h1);

    // PC priority: write port over pc_en; pc_out not bypassed
    pc_en = 1'b1; next_pc = 32'h44;
    wr0_en = 1'b1; wr0_dest = 4'd9; wr0_data = 32'h80;
    rd_a_sel = 4'd9;
    #1;
    check("pc_bypass_rd", b1_rd_a, 32'h80);
    check("pc_out_nobyp", b1_pc, 32'h40);
    tick();
    check("pc_wr_wins", n0_pc, 32'h80);
    wr0_en = 1'b0;
    rd_b_sel = 4'd9;
    #1 check("pc_next_nobyp", b1_rd_b, 32'h80);
    tick();
    check("pc_en_load", b1_pc, 32'h44);
    pc_en = 1'b0; next_pc = 32'h99;
    tick();
    check("pc_hold", g4_pc, 32'h44);

    // CPSR masked updates
    cpsr_we = 4'b0101; cpsr_in = 4'b1111;
    tick();
    check("cpsr_mask1", n0_cpsr, 32'h5000_0000);
    cpsr_we = 4'b1000; cpsr_in = 4'b0000;
    tick();
    check("cpsr_mask2", b1_cpsr, 32'h5000_0000);
    cpsr_we = 4'b0010; cpsr_in = 4'b0010;
    tick();
    cpsr_we = 4'b0000;
    check("cpsr_c_set", g4_cpsr, 32'h7000_0000);

    // SP and LR writes through both ports
    wr0_en = 1'b1; wr0_dest = 4'd8; wr0_data = 32'h200;
    wr1_en = 1'b1; wr1_dest = 4'd10; wr1_data = 32'h1234;
    rd_a_sel = 4'd8; rd_b_sel = 4'd10;
    tick();
    idle_writes();
    #1;
    check("sp_write", n0_rd_a, 32'h200);
    check("lr_write", n0_rd_b, 32'h1234);

    // NUM_GPR=4: unused GPR code, reserved code and immediate
    imm_in = 32'hCAFEF00D;
    wr0_en = 1'b1; wr0_dest = 4'd6; wr0_data = 32'h66;
    rd_a_sel = 4'd6; rd_b_sel = 4'd11; rd_c_sel = 4'd15;
    #1;
    check("g4_unused_byp", g4_rd_a, 32'h0);
    tick();
    idle_writes();
    #1;
    check("g4_unused", g4_rd_a, 32'h0);
    check("n0_r6_written", n0_rd_a, 32'h66);
    check("g4_sel11", g4_rd_b, 32'h0);
    check("g4_imm", g4_rd_c, 32'hCAFEF00D);
    check("g4_r3_kept", {28'b0, 4'd0} | (rd_a_sel == 4'd6 ? g4_rd_a : 32'h1), 32'h0);

    // Reset clears the sticky conflict and the state
    #2 rst = 1'b1;
    #1;
    rd_a_sel = 4'd3; rd_b_sel = 4'd8;
    #1;
    check("rst2_conf", {31'b0, n0_conf}, 32'h0);
    check("rst2_r3", b1_rd_a, 32'h0);
    check("rst2_sp", b1_rd_b, 32'h100);
    check("rst2_cpsr", n0_cpsr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
